// File: rtl/snes_video_sync.sv
// snes_video_sync: SNES PPU pixel stream to 6-bit RGB with active-low sync pulses
// placed inside the blanking intervals, plus measured line/frame geometry.
module snes_video_sync #(
   parameter int         HCNT_WIDTH = 9,
   parameter logic [8:0] HS_START   = 9'd16,
   parameter logic [8:0] HS_WIDTH   = 9'd24,
   parameter logic [3:0] VS_START   = 4'd3,
   parameter logic [3:0] VS_LINES   = 4'd3
) (
   input  logic                  clk_sys,
   input  logic                  reset,
   input  logic                  ce_pix,
   input  logic [4:0]            r_in,
   input  logic [4:0]            g_in,
   input  logic [4:0]            b_in,
   input  logic                  hblank,
   input  logic                  vblank,
   output logic [5:0]            R,
   output logic [5:0]            G,
   output logic [5:0]            B,
   output logic                  HSync,
   output logic                  VSync,
   output logic [HCNT_WIDTH-1:0] line_len,
   output logic [8:0]            frame_lines
);
   typedef enum logic [1:0] {H_IDLE, H_WAIT, H_PULSE} hstate_t;
   typedef enum logic [1:0] {V_IDLE, V_WAIT, V_PULSE} vstate_t;

   hstate_t               hstate;
   vstate_t               vstate;
   logic                  prev_hb, prev_vb;
   logic [HCNT_WIDTH-1:0] hcnt, hcnt_inc;
   logic [8:0]            wcnt, pcnt, vcnt;
   logic [3:0]            vwcnt, vpcnt, vw;
   logic                  h_rise, h_fall, v_rise, v_fall, blank;
   logic                  line_ev, v_arm, v_hit, v_end;

   always_comb begin
      h_rise   = hblank & ~prev_hb;
      h_fall   = ~hblank & prev_hb;
      v_rise   = vblank & ~prev_vb;
      v_fall   = ~vblank & prev_vb;
      blank    = hblank | vblank;
      hcnt_inc = &hcnt ? hcnt : hcnt + HCNT_WIDTH'(1);
      line_ev  = ce_pix & (h_rise ? HS_START == 9'd0
                                  : hstate == H_WAIT & ~h_fall & wcnt == HS_START - 9'd1);
      // a vblank rise restarts the wait count, but that ce's line event still counts
      vw       = v_rise ? 4'd0 : vwcnt;
      v_arm    = v_rise | vstate == V_WAIT;
      v_hit    = line_ev & ({1'b0, vw} + 5'd1 >= {1'b0, VS_START});
      v_end    = {1'b0, vpcnt} + 5'd1 >= {1'b0, VS_LINES};
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         R           <= '0;
         G           <= '0;
         B           <= '0;
         HSync       <= 1'b1;
         VSync       <= 1'b1;
         line_len    <= '0;
         frame_lines <= '0;
         hcnt        <= '0;
         wcnt        <= '0;
         pcnt        <= '0;
         vcnt        <= '0;
         vwcnt       <= '0;
         vpcnt       <= '0;
         hstate      <= H_IDLE;
         vstate      <= V_IDLE;
         prev_hb     <= 1'b1;
         prev_vb     <= 1'b1;
      end else if (ce_pix) begin
         prev_hb <= hblank;
         prev_vb <= vblank;
         R       <= blank ? 6'd0 : {r_in, r_in[4]};
         G       <= blank ? 6'd0 : {g_in, g_in[4]};
         B       <= blank ? 6'd0 : {b_in, b_in[4]};
         hcnt    <= h_rise ? '0 : hcnt_inc;
         if (h_rise)
            line_len <= hcnt_inc;
         if (h_rise && HS_START != 9'd0) begin
            hstate <= H_WAIT;
            wcnt   <= '0;
         end else if (line_ev) begin
            hstate <= H_PULSE;
            HSync  <= 1'b0;
            pcnt   <= '0;
         end else if (h_fall) begin
            hstate <= H_IDLE;
            HSync  <= 1'b1;
         end else if (hstate == H_WAIT) begin
            wcnt <= wcnt + 9'd1;
         end else if (hstate == H_PULSE) begin
            if (pcnt == HS_WIDTH - 9'd1) begin
               hstate <= H_IDLE;
               HSync  <= 1'b1;
            end else begin
               pcnt <= pcnt + 9'd1;
            end
         end
         if (v_rise) begin
            frame_lines <= vcnt;
            vcnt        <= {8'd0, line_ev};
         end else if (line_ev && vcnt != 9'h1FF) begin
            vcnt <= vcnt + 9'd1;
         end
         if (v_fall) begin
            vstate <= V_IDLE;
            VSync  <= 1'b1;
         end else if (v_arm) begin
            if (v_hit) begin
               vstate <= V_PULSE;
               VSync  <= 1'b0;
               vpcnt  <= '0;
            end else begin
               vstate <= V_WAIT;
               vwcnt  <= vw + {3'd0, line_ev};
            end
         end else if (vstate == V_PULSE && line_ev) begin
            if (v_end) begin
               vstate <= V_IDLE;
               VSync  <= 1'b1;
            end else begin
               vpcnt <= vpcnt + 4'd1;
            end
         end
      end
   end
endmodule

// File: doc/snes_video_sync.md
Name: snes_video_sync

Overview:
- Upstream neighbour of the MiST video pipeline.
- Takes the SNES PPU pixel stream (5-bit colour channels, hblank/vblank, pixel clock-enable) and produces what the pipeline consumes: 6-bit R/G/B, active-low HSync/VSync, blanked colour.
- Generates sync pulses at parameterised offsets inside the blanking intervals and reports measured frame geometry for OSD/debug use.

Parameters:
- HCNT_WIDTH, 9, width of the in-line pixel counter.
- HS_START, 9'd16, ce_pix pulses after hblank rise until HSync asserts.
- HS_WIDTH, 9'd24, HSync pulse length in ce_pix pulses.
- VS_START, 4'd3, line starts after vblank rise until VSync asserts.
- VS_LINES, 4'd3, VSync pulse length in lines.

Ports:
- clk_sys  in  1  master clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- ce_pix  in  1  pixel clock-enable; one pulse per pixel.
- r_in  in  5  PPU red.
- g_in  in  5  PPU green.
- b_in  in  5  PPU blue.
- hblank  in  1  horizontal blank, active-high, sampled on ce_pix.
- vblank  in  1  vertical blank, active-high, sampled on ce_pix.
- R  out  6  expanded red.
- G  out  6  expanded green.
- B  out  6  expanded blue.
- HSync  out  1  horizontal sync, active-low.
- VSync  out  1  vertical sync, active-low.
- line_len  out  HCNT_WIDTH  ce_pix count of the last complete line.
- frame_lines  out  9  line count of the last complete frame.

Behaviour:
- Interface fixed: one clock, clk_sys; reset is synchronous and active-high.
- All state updates only when ce_pix=1, except reset. Outputs are registered, so latency is 1 ce_pix from input sample to output.
- Reset values:
  - R/G/B = 0.
  - HSync = 1, VSync = 1.
  - line_len = 0, frame_lines = 0.
  - All counters = 0; hstate = H_IDLE; vstate = V_IDLE.
  - Previous-hblank and previous-vblank registers = 1, so no edge is detected on the first ce after reset.
- Colour:
  - Expansion is {c[4:0], c[4]}, e.g. 5'h1F -> 6'h3F, 5'h10 -> 6'h21.
  - Output is forced to 0 when the sampled hblank or vblank = 1.
- Horizontal counter hcnt:
  - Increments each ce_pix and saturates at all-ones.
  - On the hblank rising edge (hblank=1, prev=0): line_len <= hcnt+1 (saturating) and hcnt <= 0.
- Horizontal FSM:
  - H_IDLE -> H_WAIT on hblank rise; the wait counter loads 0.
  - H_WAIT -> H_PULSE when the wait counter reaches HS_START-1. HSync <= 0 on that transition; the pulse counter loads 0.
  - H_PULSE -> H_IDLE when the pulse counter reaches HS_WIDTH-1; HSync <= 1.
  - A hblank fall in H_WAIT or H_PULSE forces H_IDLE and HSync <= 1 (the pulse is truncated).
  - HS_START=0 asserts HSync on the same ce as the hblank rise.
  - A hblank rise while in H_PULSE is impossible, since the fall forces idle first.
- Line event: one-cycle internal strobe on each H_WAIT->H_PULSE transition (HSync falling edge).
- Vertical counter and FSM:
  - vcnt counts line events and saturates at 511.
  - On the vblank rise: frame_lines <= vcnt, vcnt <= 0, V_IDLE -> V_WAIT.
  - V_WAIT -> V_PULSE on the VS_START-th line event after the rise; VSync <= 0 on that same ce, aligned with the HSync fall.
  - V_PULSE -> V_IDLE after VS_LINES further line events; VSync <= 1 aligned with the HSync fall.
  - A vblank fall before the pulse ends forces V_IDLE and VSync=1.
  - VS_START=0 asserts VSync at the first line event after the vblank rise.
- Simultaneous events:
  - hblank and vblank rising on the same ce: the line event of that line counts toward VS_START.
  - The vcnt reset takes priority over that same-cycle increment, so vcnt = 1 after the line event.
- ce_pix held low: all outputs hold their values.
- Reset asserted mid-pulse: outputs return to reset values on the next clk_sys edge.

Test Plan:
- Reset then colour path: r_in=5'h1F, g_in=5'h10, b_in=0, blanks low, one ce -> next cycle R=6'h3F, G=6'h21, B=0, HSync=VSync=1.
- HSync timing: 340-pixel lines, hblank high for the last 64 pixels -> HSync low exactly 24 ce_pix starting 16 ce after the hblank rise; line_len=340 after the second line.
- Truncation: hblank high for only 20 pixels -> HSync low for 4 ce, back high on the ce of the hblank fall, FSM in H_IDLE.
- VSync timing: 262-line frame, vblank for 38 lines -> VSync low from the 3rd to the 6th HSync fall after the vblank rise, edges coincident with HSync falls; frame_lines=262 on the second frame.
- Blanking plus ce gating: colour 5'h1F with hblank=1 -> R/G/B=0; ce_pix held 0 for 10 cycles -> no output change.
- Reset mid-pulse: assert reset during HSync=0 and VSync=0 -> next clk_sys edge gives HSync=VSync=1, R/G/B=0, line_len=frame_lines=0; normal operation after release.
